countdown_timer_99: RTL and testbench

Two-digit BCD countdown timer, the down-counting counterpart of the 0-99 up-counting stopwatch. It loads a 00-99 preset from board switches and counts down once per second. Two raw push-button inputs are debounced internally to give start/pause and load. The BCD outputs drive the existing two-digit direct segment driver unchanged, and the block flags expiry when the count reaches 00.

---
 rtl/countdown_timer_99_if.sv | 23 ++
 rtl/countdown_timer_99.sv | 183 ++++++++++++++++++
 tb/tb_countdown_timer_99.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_99_if.sv
// Board-side signal bundle of the two-digit BCD countdown timer:
// raw keys and preset switches in, BCD digits and status flags out.
interface countdown_timer_99_if;
  logic       key_start_n;
  logic       key_load_n;
  logic [3:0] preset_tens;
  logic [3:0] preset_ones;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic       running;
  logic       done;
  logic       done_pulse;

  modport master (
    output key_start_n, key_load_n, preset_tens, preset_ones,
    input  bcd_tens, bcd_ones, running, done, done_pulse
  );

  modport slave (
    input  key_start_n, key_load_n, preset_tens, preset_ones,
    output bcd_tens, bcd_ones, running, done, done_pulse
  );
endinterface

// File: rtl/countdown_timer_99.sv
// Two-digit BCD countdown timer: debounced start/pause and load keys,
// one-second prescaler, 00-99 down counter with expiry flag and strobe.
module countdown_timer_99 #(
  parameter int CLK_HZ          = 12_000_000,
  parameter int DEBOUNCE_CYCLES = 240_000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  countdown_timer_99_if.slave  bus
);

  localparam int PW = $clog2(CLK_HZ);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic logic [3:0] clamp9(input logic [3:0] d);
    if (d > 4'd9) clamp9 = 4'd9;
    else          clamp9 = d;
  endfunction

  // Bit 0 is the start key, bit 1 the load key.
  logic [1:0]    w_key_raw;
  logic [1:0]    r_sync1, r_sync2, r_deb, r_deb_prev, r_press;
  logic [DW-1:0] r_stab [2];
  logic          w_start, w_load;

  assign w_key_raw = {bus.key_load_n, bus.key_start_n};
  assign w_start   = r_press[0];
  assign w_load    = r_press[1];

  // Synchronize, debounce and edge-detect both keys.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1    <= 2'b11;
      r_sync2    <= 2'b11;
      r_deb      <= 2'b11;
      r_deb_prev <= 2'b11;
      r_press    <= 2'b00;
      for (int k = 0; k < 2; k++) r_stab[k] <= {DW{1'b0}};
    end else begin
      r_sync1    <= w_key_raw;
      r_sync2    <= r_sync1;
      r_deb_prev <= r_deb;
      r_press    <= r_deb_prev & ~r_deb;
      for (int k = 0; k < 2; k++) begin
        if (r_sync2[k] != r_deb[k]) begin
          if (r_stab[k] == DEB_MAX) begin
            r_deb[k]  <= r_sync2[k];
            r_stab[k] <= {DW{1'b0}};
          end else begin
            r_stab[k] <= r_stab[k] + DW'(1);
          end
        end else begin
          r_stab[k] <= {DW{1'b0}};
        end
      end
    end
  end

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_tens, r_ones, w_tens_nxt, w_ones_nxt;
  logic [3:0]    w_dec_tens, w_dec_ones, w_ld_tens, w_ld_ones;
  logic [PW-1:0] r_pre, w_pre_nxt;
  logic          r_running, r_done, r_done_pulse;
  logic          w_tick, w_expire, w_nonzero;

  assign w_tick    = (r_state == S_RUN) && (r_pre == PRE_MAX);
  assign w_expire  = (r_tens == 4'd0) && (r_ones == 4'd1);
  assign w_nonzero = (r_tens != 4'd0) || (r_ones != 4'd0);
  assign w_ld_tens = clamp9(bus.preset_tens);
  assign w_ld_ones = clamp9(bus.preset_ones);

  // BCD decrement with borrow, saturating at 00.
  always_comb begin
    w_dec_tens = r_tens;
    w_dec_ones = r_ones;
    if (r_ones != 4'd0) begin
      w_dec_ones = r_ones - 4'd1;
    end else if (r_tens != 4'd0) begin
      w_dec_ones = 4'd9;
      w_dec_tens = r_tens - 4'd1;
    end else begin
      w_dec_ones = 4'd0;
      w_dec_tens = 4'd0;
    end
  end

  // Next state, count and prescaler; load beats start, tick beats load/start.
  always_comb begin
    w_state_nxt = r_state;
    w_tens_nxt  = r_tens;
    w_ones_nxt  = r_ones;
    w_pre_nxt   = {PW{1'b0}};
    case (r_state)
      S_IDLE: begin
        if (w_load) begin
          w_tens_nxt = w_ld_tens;
          w_ones_nxt = w_ld_ones;
        end else if (w_start && w_nonzero) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_tick) begin
          w_tens_nxt = w_dec_tens;
          w_ones_nxt = w_dec_ones;
          if (w_expire)     w_state_nxt = S_DONE;
          else if (w_start) w_state_nxt = S_PAUSE;
          else              w_state_nxt = S_RUN;
        end else if (w_start) begin
          w_state_nxt = S_PAUSE;
        end else begin
          w_pre_nxt = r_pre + PW'(1);
        end
      end
      S_PAUSE: begin
        if (w_load) begin
          w_tens_nxt  = w_ld_tens;
          w_ones_nxt  = w_ld_ones;
          w_state_nxt = S_IDLE;
        end else if (w_start) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_PAUSE;
        end
      end
      S_DONE: begin
        if (w_load) begin
          w_tens_nxt  = w_ld_tens;
          w_ones_nxt  = w_ld_ones;
          w_state_nxt = S_IDLE;
        end else if (w_start) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tens_nxt  = 4'd0;
        w_ones_nxt  = 4'd0;
      end
    endcase
  end

  // State, count, prescaler and registered status outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_tens       <= 4'd0;
      r_ones       <= 4'd0;
      r_pre        <= {PW{1'b0}};
      r_running    <= 1'b0;
      r_done       <= 1'b0;
      r_done_pulse <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_tens       <= w_tens_nxt;
      r_ones       <= w_ones_nxt;
      r_pre        <= w_pre_nxt;
      r_running    <= (w_state_nxt == S_RUN);
      r_done       <= (w_state_nxt == S_DONE);
      r_done_pulse <= (w_state_nxt == S_DONE) && (r_state != S_DONE);
    end
  end

  assign bus.bcd_tens   = r_tens;
  assign bus.bcd_ones   = r_ones;
  assign bus.running    = r_running;
  assign bus.done       = r_done;
  assign bus.done_pulse = r_done_pulse;

endmodule

// File: tb/tb_countdown_timer_99.sv
// Directed bench for countdown_timer_99 with CLK_HZ=10, DEBOUNCE_CYCLES=4;
// inputs change and outputs are sampled on the falling clock edge.
module tb_countdown_timer_99;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  countdown_timer_99_if ifc ();

  countdown_timer_99 #(
    .CLK_HZ          (10),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] cnt();
    return {ifc.bcd_tens, ifc.bcd_ones};
  endfunction

  // {running, done, done_pulse} in the low bits
  function automatic logic [7:0] flg();
    return {5'd0, ifc.running, ifc.done, ifc.done_pulse};
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Hold the selected keys low for 8 edges; the action lands on the last one.
  task automatic press(input logic s, input logic l);
    if (s) ifc.key_start_n = 1'b0;
    if (l) ifc.key_load_n  = 1'b0;
    wait_cyc(8);
    ifc.key_start_n = 1'b1;
    ifc.key_load_n  = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    ifc.key_start_n = 1'b1;
    ifc.key_load_n  = 1'b1;
    ifc.preset_tens = 4'd0;
    ifc.preset_ones = 4'd0;

    // reset
    wait_cyc(2);
    chk("reset_count", cnt(), 8'h00);
    chk("reset_flags", flg(), 8'h00);
    rst = 1'b0;
    wait_cyc(1);
    chk("post_reset_flags", flg(), 8'h00);

    // start with count 00 in IDLE is ignored
    ifc.key_start_n = 1'b0;
    wait_cyc(20);
    chk("start_at_00_flags", flg(), 8'h00);
    chk("start_at_00_count", cnt(), 8'h00);
    ifc.key_start_n = 1'b1;
    wait_cyc(10);

    // bouncing load key: low runs of at most 3 cycles
    ifc.preset_tens = 4'd4;
    ifc.preset_ones = 4'd2;
    for (int i = 0; i < 30; i++) begin
      ifc.key_load_n = ((i % 4) == 3) ? 1'b1 : 1'b0;
      wait_cyc(1);
    end
    ifc.key_load_n = 1'b1;
    wait_cyc(10);
    chk("bounce_no_load", cnt(), 8'h00);

    // clean hold: count changes on the 8th edge (t+7)
    ifc.key_load_n = 1'b0;
    wait_cyc(7);
    chk("load_latency_before", cnt(), 8'h00);
    wait_cyc(1);
    chk("load_latency_at", cnt(), 8'h42);
    wait_cyc(2);
    ifc.key_load_n = 1'b1;
    ifc.preset_tens = 4'd1;
    ifc.preset_ones = 4'd1;
    wait_cyc(10);
    chk("preset_change_no_effect", cnt(), 8'h42);

    // clamp and borrow
    ifc.preset_tens = 4'hC;
    ifc.preset_ones = 4'h1;
    press(1'b0, 1'b1);
    chk("clamp_load", cnt(), 8'h91);
    press(1'b1, 1'b0);
    chk("run_entry_flags", flg(), 8'h04);
    wait_cyc(9);
    chk("first_tick_before", cnt(), 8'h91);
    wait_cyc(1);
    chk("first_tick", cnt(), 8'h90);
    wait_cyc(10);
    chk("borrow", cnt(), 8'h89);
    press(1'b1, 1'b0);
    chk("pause_count", cnt(), 8'h89);
    chk("pause_flags", flg(), 8'h00);

    // expiry
    ifc.preset_tens = 4'd0;
    ifc.preset_ones = 4'd2;
    press(1'b0, 1'b1);
    chk("load_02", cnt(), 8'h02);
    press(1'b1, 1'b0);
    wait_cyc(10);
    chk("expiry_01", cnt(), 8'h01);
    wait_cyc(9);
    chk("expiry_before_flags", flg(), 8'h04);
    wait_cyc(1);
    chk("expiry_count", cnt(), 8'h00);
    chk("expiry_flags", flg(), 8'h03);
    wait_cyc(1);
    chk("done_pulse_one_cycle", flg(), 8'h02);
    press(1'b1, 1'b0);
    chk("done_to_idle_flags", flg(), 8'h00);
    chk("done_to_idle_count", cnt(), 8'h00);

    // pause and resume, partial second discarded
    ifc.preset_tens = 4'd0;
    ifc.preset_ones = 4'd5;
    press(1'b0, 1'b1);
    chk("load_05", cnt(), 8'h05);
    press(1'b1, 1'b0);
    wait_cyc(8);
    chk("run_05", cnt(), 8'h05);
    press(1'b1, 1'b0);
    chk("paused_mid_second_count", cnt(), 8'h04);
    chk("paused_mid_second_flags", flg(), 8'h00);
    wait_cyc(50);
    chk("frozen_count", cnt(), 8'h04);
    press(1'b1, 1'b0);
    chk("resume_flags", flg(), 8'h04);
    wait_cyc(9);
    chk("resume_no_early_tick", cnt(), 8'h04);
    wait_cyc(1);
    chk("resume_full_second", cnt(), 8'h03);

    // start coinciding with a tick: decrement then PAUSE
    wait_cyc(2);
    press(1'b1, 1'b0);
    chk("start_tick_count", cnt(), 8'h02);
    chk("start_tick_flags", flg(), 8'h00);

    // load and start together in PAUSE: load wins, IDLE
    wait_cyc(8);
    ifc.preset_tens = 4'd3;
    ifc.preset_ones = 4'd7;
    press(1'b1, 1'b1);
    chk("load_start_count", cnt(), 8'h37);
    chk("load_start_flags", flg(), 8'h00);
    wait_cyc(10);
    chk("idle_static", cnt(), 8'h37);

    // load ignored in RUN, then reset mid-run
    press(1'b1, 1'b0);
    chk("run_37_flags", flg(), 8'h04);
    ifc.preset_tens = 4'd1;
    ifc.preset_ones = 4'd1;
    press(1'b0, 1'b1);
    chk("load_in_run_count", cnt(), 8'h37);
    chk("load_in_run_flags", flg(), 8'h04);
    rst = 1'b1;
    wait_cyc(1);
    chk("mid_run_reset_count", cnt(), 8'h00);
    chk("mid_run_reset_flags", flg(), 8'h00);
    rst = 1'b0;
    wait_cyc(2);
    chk("after_reset_flags", flg(), 8'h00);
    chk("after_reset_count", cnt(), 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
